// File: rtl/attopu_seq_if.sv
// attopu_seq_if: unified-memory bus plus external requester port of the attopu sequencer
interface attopu_seq_if;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_we;
  logic        ext_req;
  logic        ext_we;
  logic [15:0] ext_addr;
  logic [15:0] ext_wdata;
  logic        ext_gnt;
  logic        ext_rvalid;
  modport master (
    output mem_addr, mem_wdata, mem_we, ext_gnt, ext_rvalid,
    input  mem_rdata, ext_req, ext_we, ext_addr, ext_wdata
  );
  modport slave (
    input  mem_addr, mem_wdata, mem_we, ext_gnt, ext_rvalid,
    output mem_rdata, ext_req, ext_we, ext_addr, ext_wdata
  );
endinterface

// File: rtl/attopu_seq.sv
// attopu_seq: multi-cycle fetch/execute sequencer with memory arbitration; external port enabled by ATTOPU_EXT_PORT_EN
module attopu_seq #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         run,
  output logic         halted,
  output logic [15:0]  pc,
  output logic [15:0]  ir,
  input  logic         zFlag,
  input  logic [1:0]   dec_nextPCSel,
  input  logic [15:0]  dec_addr,
  input  logic         dec_regFileWE,
  input  logic         dec_memWE,
  input  logic         dec_dAddrSel,
  input  logic         dec_regDataInSource,
  input  logic [15:0]  reg_data1,
  input  logic [15:0]  reg_data2,
  output logic         regfile_we,
  attopu_seq_if.master bus
);
`ifdef ATTOPU_EXT_PORT_EN
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_FETCH_WAIT, S_EXEC, S_LD_WAIT, S_EXT} state_t;
  logic ext_turn_q, ext_turn_d, ext_rvalid_q, ext_rvalid_d;
`else
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_FETCH_WAIT, S_EXEC, S_LD_WAIT} state_t;
`endif
  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d, ir_q, ir_d;
  logic [15:0] d_addr;
  logic        unused_ok;
  assign d_addr = dec_dAddrSel ? reg_data1 : dec_addr;
  assign halted = state_q == S_IDLE;
  assign pc = pc_q;
  assign ir = ir_q;
  // State, PC and instruction register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q <= RESET_PC;
      ir_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
    end
  end
  // Next state; PC commits in EXEC, IR loads one cycle after the fetch address
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    case (state_q)
`ifdef ATTOPU_EXT_PORT_EN
      S_IDLE: state_d = bus.ext_req ? S_EXT : run ? S_FETCH : S_IDLE;
      S_FETCH: state_d = (bus.ext_req && ext_turn_q) ? S_EXT : !run ? S_IDLE : S_FETCH_WAIT;
      S_EXT: state_d = run ? S_FETCH : S_IDLE;
`else
      S_IDLE: state_d = run ? S_FETCH : S_IDLE;
      S_FETCH: state_d = run ? S_FETCH_WAIT : S_IDLE;
`endif
      S_FETCH_WAIT: begin
        ir_d = bus.mem_rdata;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        pc_d = dec_nextPCSel[1] ? reg_data1 : dec_nextPCSel[0] ? pc_q + dec_addr : pc_q + 16'd1;
        state_d = dec_regDataInSource ? S_LD_WAIT : S_FETCH;
      end
      S_LD_WAIT: state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end
  // Strobes and memory-bus mux; the fetch address is only driven when the fetch really proceeds
  always_comb begin
    regfile_we = 1'b0;
    bus.mem_we = 1'b0;
    bus.mem_addr = 16'h0000;
    bus.mem_wdata = 16'h0000;
    bus.ext_gnt = 1'b0;
    case (state_q)
      S_FETCH: bus.mem_addr = (state_d == S_FETCH_WAIT) ? pc_q : 16'h0000;
      S_EXEC: begin
        regfile_we = dec_regFileWE & ~dec_regDataInSource;
        bus.mem_we = dec_memWE;
        bus.mem_addr = (dec_memWE | dec_regDataInSource) ? d_addr : 16'h0000;
        bus.mem_wdata = dec_memWE ? reg_data2 : 16'h0000;
      end
      S_LD_WAIT: regfile_we = 1'b1;
`ifdef ATTOPU_EXT_PORT_EN
      S_EXT: begin
        bus.ext_gnt = 1'b1;
        bus.mem_we = bus.ext_we;
        bus.mem_addr = bus.ext_addr;
        bus.mem_wdata = bus.ext_wdata;
      end
`endif
      default: ;
    endcase
  end
`ifdef ATTOPU_EXT_PORT_EN
  // Turn returns to the external port after each completed instruction; read-valid trails a read grant
  always_comb begin
    ext_turn_d = (state_q == S_EXEC || state_q == S_LD_WAIT) ? 1'b1 : (state_q == S_EXT) ? 1'b0 : ext_turn_q;
    ext_rvalid_d = (state_q == S_EXT) & ~bus.ext_we;
  end
  // Arbitration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_turn_q <= 1'b1;
      ext_rvalid_q <= 1'b0;
    end else begin
      ext_turn_q <= ext_turn_d;
      ext_rvalid_q <= ext_rvalid_d;
    end
  end
  assign bus.ext_rvalid = ext_rvalid_q;
  assign unused_ok = zFlag;
`else
  assign bus.ext_rvalid = 1'b0;
  assign unused_ok = ^{zFlag, bus.ext_req, bus.ext_we, bus.ext_addr, bus.ext_wdata};
`endif
endmodule
